// File: rtl/z80_pkg.sv
// Shared Z80 bus-sequencer types: machine-cycle kinds, T-states and width defaults.
// Used by the M-cycle sequencer, the decoder and the control FSM.
package z80_pkg;

   localparam int Z80_ADDR_W = 16;
   localparam int Z80_DATA_W = 8;

   typedef enum logic [2:0] {
      OCF = 3'd0,
      MR  = 3'd1,
      MW  = 3'd2,
      PR  = 3'd3,
      PW  = 3'd4
   } mcycle_t;

   typedef enum logic [2:0] {
      IDLE, T1, T2, TWA, TW, T3, T4
   } tstate_t;

   function automatic logic legal_type(input logic [2:0] t);
      return t <= 3'd4;
   endfunction

   function automatic logic is_read(input mcycle_t t);
      return (t == OCF) || (t == MR) || (t == PR);
   endfunction

   function automatic logic is_port(input mcycle_t t);
      return (t == PR) || (t == PW);
   endfunction

endpackage

// File: rtl/z80_rfsh_ctr.sv
// Refresh register R: low seven bits count completed opcode fetches, bit 7 is sticky.
// The load port lets an LD R,A path write the whole register.
module z80_rfsh_ctr (
   input  logic       clk,
   input  logic       rst_L,
   input  logic       inc,
   input  logic       ld,
   input  logic [7:0] ld_val,
   output logic [7:0] r_out
);

   logic [7:0] r_cnt;

   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         r_cnt <= 8'h00;
      end else if (ld) begin
         r_cnt <= ld_val;
      end else if (inc) begin
         r_cnt <= {r_cnt[7], r_cnt[6:0] + 7'd1};
      end
   end

   assign r_out = r_cnt;

endmodule

// File: rtl/z80_mcycle_fsm.sv
// Z80 machine-cycle sequencer: runs one bus M-cycle (fetch, mem/port read/write) per accepted start.
// Strobes decode only from the registered T-state and latched cycle type.
module z80_mcycle_fsm
   import z80_pkg::*;
#(
   parameter int ADDR_W   = Z80_ADDR_W,
   parameter int DATA_W   = Z80_DATA_W,
   parameter int IO_WAITS = 1
) (
   input  logic              clk,
   input  logic              rst_L,
   input  logic              start,
   input  logic [2:0]        cycle_type,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [DATA_W-1:0] wdata_in,
   input  logic [7:0]        i_reg,
   input  logic [DATA_W-1:0] data_in,
   input  logic              WAIT_L,
   output logic              ready,
   output logic              done,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic [ADDR_W-1:0] addr_out,
   output logic [DATA_W-1:0] data_out,
   output logic              data_oe,
   output logic              M1_L,
   output logic              MREQ_L,
   output logic              IORQ_L,
   output logic              RD_L,
   output logic              WR_L,
   output logic              RFSH_L,
   output logic [7:0]        r_reg
);

   tstate_t           r_state;
   tstate_t           w_state_next;
   mcycle_t           r_type;
   mcycle_t           w_type_in;
   logic [1:0]        r_wcnt;
   logic [1:0]        w_wcnt_next;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rd_data;
   logic              w_accept;
   logic              w_enter_t3;
   logic              w_done;
   logic [ADDR_W-1:0] w_rfsh_addr;

   assign w_type_in   = mcycle_t'(cycle_type);
   assign w_done      = (r_state == T4) || ((r_state == T3) && (r_type != OCF));
   assign ready       = (r_state == IDLE) || w_done;
   assign w_accept    = ready && start && legal_type(cycle_type);
   assign w_enter_t3  = (r_state inside {T2, TWA, TW}) && (w_state_next == T3);
   assign w_rfsh_addr = ADDR_W'({i_reg, r_reg});

   always_comb begin
      w_state_next = r_state;
      w_wcnt_next  = r_wcnt;
      case (r_state)
         IDLE: if (w_accept) w_state_next = T1;
         T1:   w_state_next = T2;
         T2: begin
            if (is_port(r_type) && (IO_WAITS > 0)) begin
               w_state_next = TWA;
               w_wcnt_next  = 2'd1;
            end else if (!WAIT_L) begin
               w_state_next = TW;
            end else begin
               w_state_next = T3;
            end
         end
         TWA: begin
            // Mandatory I/O waits run to completion before WAIT_L is looked at.
            if (int'(r_wcnt) < IO_WAITS) begin
               w_wcnt_next = r_wcnt + 2'd1;
            end else if (!WAIT_L) begin
               w_state_next = TW;
            end else begin
               w_state_next = T3;
            end
         end
         TW:   if (WAIT_L) w_state_next = T3;
         T3: begin
            if (r_type == OCF)  w_state_next = T4;
            else if (w_accept)  w_state_next = T1;
            else                w_state_next = IDLE;
         end
         T4:      w_state_next = w_accept ? T1 : IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         r_state   <= IDLE;
         r_type    <= OCF;
         r_wcnt    <= 2'd0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_rd_data <= '0;
      end else begin
         r_state <= w_state_next;
         r_wcnt  <= w_wcnt_next;
         if (w_accept) begin
            r_type <= w_type_in;
            r_addr <= addr_in;
            if ((w_type_in == MW) || (w_type_in == PW)) r_wdata <= wdata_in;
         end
         if (w_enter_t3) begin
            if (is_read(r_type)) r_rd_data <= data_in;
            if (r_type == OCF)   r_addr    <= w_rfsh_addr;
         end
      end
   end

   // Idle state gates every strobe, so a stale r_type never reaches the pins.
   always_comb begin
      M1_L    = 1'b1;
      MREQ_L  = 1'b1;
      IORQ_L  = 1'b1;
      RD_L    = 1'b1;
      WR_L    = 1'b1;
      RFSH_L  = 1'b1;
      data_oe = 1'b0;
      case (r_type)
         OCF: begin
            if (r_state inside {T1, T2, TW}) begin
               M1_L   = 1'b0;
               MREQ_L = 1'b0;
               RD_L   = 1'b0;
            end
            if (r_state inside {T3, T4}) begin
               RFSH_L = 1'b0;
               MREQ_L = 1'b0;
            end
         end
         MR: begin
            if (r_state inside {T1, T2, TW}) begin
               MREQ_L = 1'b0;
               RD_L   = 1'b0;
            end
         end
         MW: begin
            if (r_state inside {T1, T2, TW})     MREQ_L  = 1'b0;
            if (r_state inside {T2, TW})         WR_L    = 1'b0;
            if (r_state inside {T1, T2, TW, T3}) data_oe = 1'b1;
         end
         PR: begin
            if (r_state inside {T2, TWA, TW}) begin
               IORQ_L = 1'b0;
               RD_L   = 1'b0;
            end
         end
         PW: begin
            if (r_state inside {T2, TWA, TW}) begin
               IORQ_L = 1'b0;
               WR_L   = 1'b0;
            end
            if (r_state inside {T1, T2, TWA, TW, T3}) data_oe = 1'b1;
         end
         default: ;
      endcase
   end

   z80_rfsh_ctr u_rfsh (
      .clk    (clk),
      .rst_L  (rst_L),
      .inc    (r_state == T4),
      .ld     (1'b0),
      .ld_val (8'h00),
      .r_out  (r_reg)
   );

   assign done     = w_done;
   assign rd_valid = (r_state == T3) && is_read(r_type);
   assign rd_data  = r_rd_data;
   assign addr_out = r_addr;
   assign data_out = r_wdata;

endmodule

// File: tb/tb_z80_mcycle_fsm.sv
// Bench for z80_mcycle_fsm: directed table, hand-written corner sequences and a random run
// checked against a cycle-count model derived from the bus-cycle rules.
module tb_z80_mcycle_fsm;

   localparam int IOW = 1;

   logic        clk = 1'b0;
   logic        rst_L = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  cycle_type = 3'd0;
   logic [15:0] addr_in = 16'h0;
   logic [7:0]  wdata_in = 8'h0;
   logic [7:0]  i_reg = 8'h0;
   logic [7:0]  data_in = 8'h0;
   logic        WAIT_L = 1'b1;
   logic        ready, done, rd_valid, data_oe;
   logic [7:0]  rd_data, data_out, r_reg;
   logic [15:0] addr_out;
   logic        M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L;
   logic [5:0]  strobes;

   logic        ctr_inc = 1'b0;
   logic        ctr_ld = 1'b0;
   logic [7:0]  ctr_val = 8'h0;
   logic [7:0]  ctr_r;

   assign strobes = {M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L};

   always #5 clk = ~clk;

   z80_mcycle_fsm #(.ADDR_W(16), .DATA_W(8), .IO_WAITS(IOW)) dut (
      .clk(clk), .rst_L(rst_L), .start(start), .cycle_type(cycle_type),
      .addr_in(addr_in), .wdata_in(wdata_in), .i_reg(i_reg), .data_in(data_in),
      .WAIT_L(WAIT_L), .ready(ready), .done(done), .rd_data(rd_data),
      .rd_valid(rd_valid), .addr_out(addr_out), .data_out(data_out),
      .data_oe(data_oe), .M1_L(M1_L), .MREQ_L(MREQ_L), .IORQ_L(IORQ_L),
      .RD_L(RD_L), .WR_L(WR_L), .RFSH_L(RFSH_L), .r_reg(r_reg)
   );

   z80_rfsh_ctr ctr (
      .clk(clk), .rst_L(rst_L), .inc(ctr_inc), .ld(ctr_ld), .ld_val(ctr_val), .r_out(ctr_r)
   );

   typedef struct {
      logic [2:0]  ty;
      logic [15:0] a;
      logic [7:0]  wd;
      logic [7:0]  din;
      logic [7:0]  iv;
      logic [15:0] wp;
      int          e_lat, e_m1, e_rd, e_wr, e_iorq, e_rfsh, e_oe;
      int          e_rdata, e_raddr, e_r;
   } vec_t;

   int total = 0;
   int bad = 0;
   logic [7:0] exp_r = 8'h00;
   logic [7:0] exp_rd = 8'h00;

   int m_lat, m_m1, m_mreq, m_iorq, m_rd, m_wr, m_rfsh, m_oe, m_rv;
   int m_rfsh_addr, m_addr1, m_dout1, m_mreq1, m_r1, m_rdata, m_ready;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Entered at a negedge with the DUT able to accept; returns at the negedge of the done cycle.
   // wp bit k is the WAIT_L level driven during cycle k after the accept edge.
   task automatic run_mc(input logic [2:0] ty, input logic [15:0] a, input logic [7:0] wd,
                         input logic [7:0] din, input logic [7:0] iv, input logic [15:0] wp);
      cycle_type = ty; addr_in = a; wdata_in = wd; data_in = din; i_reg = iv;
      WAIT_L = wp[0]; start = 1'b1;
      m_lat = -1; m_m1 = 0; m_mreq = 0; m_iorq = 0; m_rd = 0; m_wr = 0;
      m_rfsh = 0; m_oe = 0; m_rv = 0; m_rfsh_addr = -1; m_addr1 = -1; m_dout1 = -1;
      m_mreq1 = -1; m_r1 = -1; m_rdata = -1; m_ready = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 1) begin
            start = 1'b0;
            addr_in = 16'($urandom);
            wdata_in = 8'($urandom);
            m_addr1 = int'(addr_out);
            m_dout1 = int'(data_out);
            m_mreq1 = int'(MREQ_L);
            m_r1 = int'(r_reg);
         end
         WAIT_L = (k < 16) ? wp[k] : 1'b1;
         if (!M1_L)   m_m1++;
         if (!MREQ_L) m_mreq++;
         if (!IORQ_L) m_iorq++;
         if (!RD_L)   m_rd++;
         if (!WR_L)   m_wr++;
         if (!RFSH_L) begin
            m_rfsh++;
            m_rfsh_addr = int'(addr_out);
         end
         if (data_oe)  m_oe++;
         if (rd_valid) m_rv++;
         if (done) begin
            m_lat = k;
            m_rdata = int'(rd_data);
            m_ready = int'(ready);
            break;
         end
      end
      WAIT_L = 1'b1;
   endtask

   // Expected behaviour from the cycle rules: base latency plus one per consecutive WAIT_L=0
   // sample starting at the first sampling point, strobe windows as counts of cycles.
   task automatic check_mc(input logic [2:0] ty, input logic [15:0] a, input logic [7:0] wd,
                           input logic [7:0] din, input logic [7:0] iv, input logic [15:0] wp,
                           input int id);
      int f, n, lat, pre;
      bit is_o, is_p, is_r, is_w;
      is_o = (ty == 3'd0);
      is_p = (ty == 3'd3) || (ty == 3'd4);
      is_r = (ty == 3'd0) || (ty == 3'd1) || (ty == 3'd3);
      is_w = (ty == 3'd2) || (ty == 3'd4);
      f = is_p ? 2 + IOW : 2;
      n = 0;
      while ((f + n < 16) && (wp[f + n] == 1'b0)) n++;
      lat = (is_o ? 4 : (is_p ? 3 + IOW : 3)) + n;
      pre = lat - (is_o ? 2 : 1);
      run_mc(ty, a, wd, din, iv, wp);
      chk("latency", m_lat, lat);
      chk("m1_cycles", m_m1, is_o ? pre : 0);
      chk("mreq_cycles", m_mreq, is_o ? lat : (((ty == 3'd1) || (ty == 3'd2)) ? pre : 0));
      chk("iorq_cycles", m_iorq, is_p ? pre - 1 : 0);
      chk("rd_cycles", m_rd, (is_o || (ty == 3'd1)) ? pre : ((ty == 3'd3) ? pre - 1 : 0));
      chk("wr_cycles", m_wr, is_w ? pre - 1 : 0);
      chk("rfsh_cycles", m_rfsh, is_o ? 2 : 0);
      chk("oe_cycles", m_oe, is_w ? lat : 0);
      chk("rd_valid_pulses", m_rv, is_r ? 1 : 0);
      chk("addr_t1", m_addr1, int'(a));
      if (is_w) chk("data_out", m_dout1, int'(wd));
      chk("r_before", m_r1, int'(exp_r));
      chk("ready_at_done", m_ready, 1);
      if (is_r) exp_rd = din;
      chk("rd_data", m_rdata, int'(exp_rd));
      if (is_o) begin
         chk("rfsh_addr", m_rfsh_addr, int'({iv, exp_r}));
         exp_r = {exp_r[7], exp_r[6:0] + 7'd1};
      end
      $display("txn %0d: type=%0d addr=%h waits=%0d latency=%0d", id, ty, a, n, m_lat);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[7];
      int cnt;
      logic [2:0]  ty;
      logic [15:0] wp;
      int fr;

      tbl[0] = '{3'd0, 16'h1234, 8'h00, 8'h3E, 8'h80, 16'hFFFF, 4, 2, 2, 0, 0, 2, 0, 'h3E, 'h8000, 'h01};
      tbl[1] = '{3'd1, 16'h4000, 8'h00, 8'hA5, 8'h80, 16'hFFF3, 5, 0, 4, 0, 0, 0, 0, 'hA5, 0, 'h01};
      tbl[2] = '{3'd4, 16'h00FE, 8'h5A, 8'h00, 8'h80, 16'hFFFF, 4, 0, 0, 2, 2, 0, 4, 'hA5, 0, 'h01};
      tbl[3] = '{3'd3, 16'h0012, 8'h00, 8'hC3, 8'h80, 16'hFFF1, 5, 0, 3, 0, 3, 0, 0, 'hC3, 0, 'h01};
      tbl[4] = '{3'd2, 16'h8001, 8'h77, 8'h00, 8'h80, 16'hFFFB, 4, 0, 0, 2, 0, 0, 4, 'hC3, 0, 'h01};
      tbl[5] = '{3'd0, 16'h0100, 8'h00, 8'h00, 8'h12, 16'hFFF7, 4, 2, 2, 0, 0, 2, 0, 'h00, 'h1201, 'h02};
      tbl[6] = '{3'd4, 16'h0055, 8'h99, 8'h00, 8'h12, 16'hFFFB, 4, 0, 0, 2, 2, 0, 4, 'h00, 0, 'h02};

      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk("reset_strobes", int'(strobes), 'h3F);
      chk("reset_ready", int'(ready), 1);
      chk("reset_done_rv_oe", int'({done, rd_valid, data_oe}), 0);
      chk("reset_addr", int'(addr_out), 0);
      chk("reset_data_rd_r", int'({data_out, rd_data, r_reg}), 0);
      rst_L = 1'b1;
      @(negedge clk);

      // Directed table
      for (int i = 0; i < 7; i++) begin
         run_mc(tbl[i].ty, tbl[i].a, tbl[i].wd, tbl[i].din, tbl[i].iv, tbl[i].wp);
         chk("tbl_latency", m_lat, tbl[i].e_lat);
         chk("tbl_m1", m_m1, tbl[i].e_m1);
         chk("tbl_rd", m_rd, tbl[i].e_rd);
         chk("tbl_wr", m_wr, tbl[i].e_wr);
         chk("tbl_iorq", m_iorq, tbl[i].e_iorq);
         chk("tbl_rfsh", m_rfsh, tbl[i].e_rfsh);
         chk("tbl_oe", m_oe, tbl[i].e_oe);
         chk("tbl_rd_data", m_rdata, tbl[i].e_rdata);
         chk("tbl_addr_t1", m_addr1, int'(tbl[i].a));
         if (tbl[i].e_rfsh > 0) chk("tbl_rfsh_addr", m_rfsh_addr, tbl[i].e_raddr);
         if (tbl[i].e_wr > 0)   chk("tbl_data_out", m_dout1, int'(tbl[i].wd));
         @(negedge clk);
         chk("tbl_r_after", int'(r_reg), tbl[i].e_r);
         $display("vec %0d: type=%0d latency=%0d rd_data=%h r=%h", i, tbl[i].ty, m_lat, rd_data, r_reg);
      end
      exp_r = 8'h02;
      exp_rd = 8'h00;

      // Back-to-back: MW started in the T4 of an OCF
      check_mc(3'd0, 16'h2000, 8'h00, 8'h11, 8'h40, 16'hFFFF, 100);
      check_mc(3'd2, 16'h3000, 8'h66, 8'h00, 8'h40, 16'hFFFF, 101);
      chk("b2b_mreq_t1", m_mreq1, 0);

      // Reset in T2 of an MR
      @(negedge clk);
      cycle_type = 3'd1; addr_in = 16'h2222; data_in = 8'hEE; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("pre_reset_rd", int'(RD_L), 0);
      rst_L = 1'b0;
      #1;
      chk("midreset_strobes", int'(strobes), 'h3F);
      chk("midreset_ready", int'(ready), 1);
      chk("midreset_addr", int'(addr_out), 0);
      chk("midreset_r", int'(r_reg), 0);
      @(negedge clk);
      rst_L = 1'b1;
      cnt = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (done || (strobes != 6'h3F)) cnt++;
      end
      chk("no_done_after_reset", cnt, 0);
      chk("rd_data_after_reset", int'(rd_data), 0);
      exp_r = 8'h00;
      exp_rd = 8'h00;

      // Illegal cycle types are ignored
      start = 1'b1;
      cnt = 0;
      for (int k = 0; k < 4; k++) begin
         cycle_type = 3'(5 + (k % 3));
         @(negedge clk);
         if (done || !ready || data_oe || (strobes != 6'h3F)) cnt++;
      end
      start = 1'b0;
      chk("illegal_ignored", cnt, 0);
      check_mc(3'd1, 16'h5555, 8'h00, 8'h3C, 8'h00, 16'hFFFF, 102);

      // R wraps its low seven bits after 128 fetches
      for (int i = 0; i < 128; i++) begin
         check_mc(3'd0, 16'($urandom), 8'h00, 8'($urandom), 8'($urandom), 16'hFFFF, 200 + i);
      end
      @(negedge clk);
      chk("r_wrap", int'(r_reg), 0);

      // Bit 7 of R survives increments
      ctr_ld = 1'b1; ctr_val = 8'hFF;
      @(negedge clk);
      ctr_ld = 1'b0; ctr_inc = 1'b1;
      @(negedge clk);
      ctr_inc = 1'b0;
      chk("r_bit7_wrap", int'(ctr_r), 'h80);
      ctr_inc = 1'b1;
      @(negedge clk);
      ctr_inc = 1'b0;
      chk("r_bit7_inc", int'(ctr_r), 'h81);

      // Random traffic against the model
      for (int i = 0; i < 200; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         ty = 3'($urandom_range(0, 4));
         fr = ((ty == 3'd3) || (ty == 3'd4)) ? 2 + IOW : 2;
         wp = 16'($urandom) | (16'hFFFF << (fr + 3));
         check_mc(ty, 16'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), wp, 400 + i);
      end

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/z80_mcycle_fsm.md
# z80_mcycle_fsm

Parametrised Z80 machine-cycle sequencer that drives the external bus for one M-cycle per request. It supports opcode fetch with refresh, memory read and write, and port read and write. It also handles WAIT_L insertion, automatic I/O wait states and refresh-register maintenance. It sits between the control FSM/decoder, which issues one `start` per M-cycle, and the top-level bus pins.

## Interface
Parameters:
- ADDR_W, default 16: address bus width.
- DATA_W, default 8: data bus width.
- IO_WAITS, default 1: mandatory wait states inserted in port cycles (0–3).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_L  in  1  reset, asynchronous, active-low.
- start  in  1  request one M-cycle; sampled only when `ready`=1.
- cycle_type  in  3  `mcycle_t`: OCF=0, MR=1, MW=2, PR=3, PW=4; codes 5–7 illegal.
- addr_in  in  ADDR_W  cycle address, latched on accept.
- wdata_in  in  DATA_W  write data for MW/PW, latched on accept.
- i_reg  in  8  I register; upper refresh-address byte.
- data_in  in  DATA_W  external data bus.
- WAIT_L  in  1  external wait request, active-low.
- ready  out  1  can accept `start` this cycle.
- done  out  1  one-cycle pulse in the final T-state.
- rd_data  out  DATA_W  captured read/opcode byte; held until the next capture.
- rd_valid  out  1  one-cycle pulse when `rd_data` is updated.
- addr_out  out  ADDR_W  address bus.
- data_out  out  DATA_W  write data.
- data_oe  out  1  data bus drive enable.
- M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L  out  1 each  bus strobes, active-low.
- r_reg  out  8  refresh register R.

## Operation
- States (`tstate_t`): IDLE, T1, T2, TWA (auto wait), TW (external wait), T3, T4.
- **Accept.** `start`=1 with a legal type while `ready`=1 latches type, address and wdata, then enters T1 next cycle.
  - `ready`=1 in IDLE and in the final T-state, so back-to-back cycles are possible with no IDLE gap.
  - An illegal type is ignored: no state change, no `done`.
- **Wait insertion.** On leaving T2 and TWA, go to TW if WAIT_L=0. TW repeats while WAIT_L=0; otherwise go to T3.
- **Auto waits.** PR/PW go T2 → TWA × IO_WAITS → (TW)* → T3. With IO_WAITS=0, TWA is skipped.
- **Read capture.** Data is captured into `rd_data` on the edge leaving the last T2/TWA/TW into T3. `rd_valid` pulses in T3.
- **OCF:** T1 → T2 → (TW)* → T3 → T4.
  - T1–T2/TW: addr_out = latched address; M1_L=0, MREQ_L=0, RD_L=0.
  - T3–T4: addr_out = {i_reg, r_reg} zero-extended to ADDR_W; RFSH_L=0, MREQ_L=0; M1_L=1 and RD_L=1.
  - `done` pulses in T4.
  - Edge leaving T4: r_reg[6:0] increments modulo 128; r_reg[7] is unchanged.
- **MR:** T1 → T2 → (TW)* → T3. MREQ_L=0 and RD_L=0 in T1–T2/TW. `done` pulses in T3.
- **MW:** T1 → T2 → (TW)* → T3.
  - MREQ_L=0 in T1–T2/TW.
  - WR_L=0 in T2/TW.
  - data_oe=1 and data_out = wdata in T1–T3.
  - `done` pulses in T3.
- **PR:** IORQ_L=0 and RD_L=0 in T2/TWA/TW. `done` pulses in T3.
- **PW:** IORQ_L=0 and WR_L=0 in T2/TWA/TW. data_oe=1 in T1–T3. `done` pulses in T3.
- Outside these windows, strobes are 1, data_oe=0 and addr_out holds its last value.
- **Reset values:** all `_L` outputs 1; addr_out, data_out, rd_data, r_reg = 0; data_oe, done, rd_valid = 0; ready=1; state IDLE.
- **Reset mid-cycle** forces the reset values immediately. The in-flight cycle is abandoned with no `done` pulse.

## Timing
- Strobes are decoded combinationally from the registered state and the latched type only; there is no path from `start` to the pins.
- Latency from the accept edge to the `done` cycle, with no waits:
  - OCF: 4 cycles.
  - MR/MW: 3 cycles.
  - PR/PW: 3+IO_WAITS cycles.
- Each WAIT_L=0 sample adds exactly one cycle.
- WAIT_L is sampled only on exit from T2/TWA/TW and ignored in every other state.
- r_reg is updated only on a completed OCF.

## Structure
- Package `z80_pkg` holds `mcycle_t`, `tstate_t` and the width constants; the decoder and control FSM share it.
- Sub-module `z80_rfsh_ctr` is the 7-bit R counter with preserved bit 7, incremented on `inc`.

## Test plan
- **OCF, no wait.** addr_in=0x1234, data_in=0x3E, i_reg=0x80 → M1_L low for 2 cycles, then addr_out=0x8000 with RFSH_L low for 2 cycles. rd_data=0x3E, `done` at accept+4, r_reg=0x01.
- **MR with WAIT_L.** Hold WAIT_L low for 2 samples, data_in=0xA5 → RD_L low for 4 cycles, rd_data=0xA5, `done` at accept+5.
- **PW.** IO_WAITS=1, wdata_in=0x5A, addr_in=0x00FE → IORQ_L/WR_L low for 2 cycles, data_oe high for 4 cycles, data_out=0x5A, `done` at accept+4.
- **Back-to-back.** OCF followed by MW, with `start` asserted in T4 → the MW T1 starts on the next cycle with no IDLE gap.
- **R wrap.** r_reg=0xFF before an OCF → r_reg=0x80 after it.
- **Reset and illegal type.** Assert rst_L low during T2 of MR → strobes go 1 immediately and no `done` follows. An illegal `cycle_type` on `start` → the block stays IDLE.
